reduction_tree_acc: RTL

Parametrised, fully pipelined reduction unit. It folds a phit of LANES signed integer elements to one scalar using a selectable operator (SUM, MAX or MIN), then accumulates successive phits until an end-of-packet marker arrives. It sits behind the phit receive path and is the generalised successor of the fixed 8-input adder tree. It adds lane masking, operator modes, multi-beat accumulation and valid tracking.

---
 rtl/reduce_pkg.sv | 35 +++
 rtl/reduce_node.sv | 57 +++++
 rtl/reduction_tree_acc.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
// Shared mode encoding and element arithmetic for the lane reduction tree and its accumulator.
package reduce_pkg;

  // Values are passed sign-extended to MAX_DW so one function serves every element width.
  localparam int MAX_DW = 256;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_MAX  = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  function automatic logic signed [MAX_DW-1:0] identity(input mode_e mode, input int width);
    logic signed [MAX_DW-1:0] ones;
    ones = '1;
    case (mode)
      MODE_MAX: identity = ones << (width - 1);
      MODE_MIN: identity = ~(ones << (width - 1));
      default:  identity = '0;
    endcase
  endfunction

  // The reserved mode folds as SUM; the error is tracked separately.
  function automatic logic signed [MAX_DW-1:0] combine(input mode_e mode,
                                                       input logic signed [MAX_DW-1:0] a,
                                                       input logic signed [MAX_DW-1:0] b);
    case (mode)
      MODE_MAX: combine = (a > b) ? a : b;
      MODE_MIN: combine = (a < b) ? a : b;
      default:  combine = a + b;
    endcase
  endfunction

endpackage

// File: rtl/reduce_node.sv
// One registered two-input reduction node; sideband travels alongside the combined value.
module reduce_node
  import reduce_pkg::*;
#(
  parameter int DWIDTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] a_data,
  input  logic              a_valid,
  input  logic              a_last,
  input  logic              a_err,
  input  logic [1:0]        a_mode,
  input  logic [DWIDTH-1:0] b_data,
  input  logic              b_valid,
  input  logic              b_last,
  input  logic              b_err,
  input  logic [1:0]        b_mode,
  output logic [DWIDTH-1:0] y_data,
  output logic              y_valid,
  output logic              y_last,
  output logic              y_err,
  output logic [1:0]        y_mode
);

  logic [DWIDTH-1:0] data_reg, data_next;
  logic              valid_reg, last_reg, err_reg;
  logic [1:0]        mode_reg;

  assign data_next = DWIDTH'(combine(mode_e'(a_mode),
                                     MAX_DW'(signed'(a_data)),
                                     MAX_DW'(signed'(b_data))));

  // Both children always carry the same beat, so merging the sidebands is lossless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
      mode_reg  <= '0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= a_valid | b_valid;
      last_reg  <= a_last | b_last;
      err_reg   <= a_err | b_err | (a_mode != b_mode);
      mode_reg  <= a_mode;
    end
  end

  assign y_data  = data_reg;
  assign y_valid = valid_reg;
  assign y_last  = last_reg;
  assign y_err   = err_reg;
  assign y_mode  = mode_reg;

endmodule

// File: rtl/reduction_tree_acc.sv
// Masks a phit of signed lanes, folds it through a pipelined SUM/MAX/MIN tree,
// and accumulates successive phits into one result per packet.
module reduction_tree_acc
  import reduce_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DWIDTH = 64,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LANES*DWIDTH-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  input  logic [1:0]              in_mode,
  input  logic                    in_last,
  output logic                    out_valid,
  output logic [DWIDTH-1:0]       out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_err
);

  localparam int NODES = 2 * LANES - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Heap layout: node 0 is the root, lanes occupy indices LANES-1 .. 2*LANES-2.
  logic [DWIDTH-1:0] node_data  [NODES];
  logic              node_valid [NODES];
  logic              node_last  [NODES];
  logic              node_err   [NODES];
  logic [1:0]        node_mode  [NODES];

  logic [DWIDTH-1:0] ident_val;
  assign ident_val = DWIDTH'(identity(mode_e'(in_mode), DWIDTH));

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign node_data[LANES-1+gi]  = in_mask[gi] ? in_data[gi*DWIDTH +: DWIDTH] : ident_val;
      assign node_valid[LANES-1+gi] = in_valid;
      assign node_last[LANES-1+gi]  = in_valid & in_last;
      assign node_err[LANES-1+gi]   = (in_mode == MODE_RSVD);
      assign node_mode[LANES-1+gi]  = in_mode;
    end

    for (gi = 0; gi < LANES - 1; gi++) begin : g_node
      reduce_node #(.DWIDTH(DWIDTH)) u_node (
        .clk     (clk),
        .rst     (rst),
        .a_data  (node_data[2*gi+1]),
        .a_valid (node_valid[2*gi+1]),
        .a_last  (node_last[2*gi+1]),
        .a_err   (node_err[2*gi+1]),
        .a_mode  (node_mode[2*gi+1]),
        .b_data  (node_data[2*gi+2]),
        .b_valid (node_valid[2*gi+2]),
        .b_last  (node_last[2*gi+2]),
        .b_err   (node_err[2*gi+2]),
        .b_mode  (node_mode[2*gi+2]),
        .y_data  (node_data[gi]),
        .y_valid (node_valid[gi]),
        .y_last  (node_last[gi]),
        .y_err   (node_err[gi]),
        .y_mode  (node_mode[gi])
      );
    end
  endgenerate

  state_e            state_reg, state_next;
  logic [DWIDTH-1:0] acc_reg, acc_next;
  logic [1:0]        pkt_mode_reg, pkt_mode_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              err_reg, err_next;
  logic              out_valid_reg, out_valid_next;
  logic [DWIDTH-1:0] out_data_reg, out_data_next;
  logic [CNT_W-1:0]  out_count_reg, out_count_next;
  logic              out_err_reg, out_err_next;

  logic [DWIDTH-1:0] fold_data;
  logic [CNT_W-1:0]  fold_count;
  logic              fold_err;
  logic [1:0]        fold_mode;

  // Packet state after absorbing the beat currently leaving the tree.
  always_comb begin
    fold_data  = node_data[0];
    fold_count = CNT_W'(1);
    fold_err   = node_err[0];
    fold_mode  = node_mode[0];
    if (state_reg == ST_ACC) begin
      fold_data  = DWIDTH'(combine(mode_e'(pkt_mode_reg),
                                   MAX_DW'(signed'(acc_reg)),
                                   MAX_DW'(signed'(node_data[0]))));
      fold_count = (count_reg == {CNT_W{1'b1}}) ? count_reg : count_reg + CNT_W'(1);
      fold_err   = err_reg | node_err[0] | (node_mode[0] != pkt_mode_reg);
      fold_mode  = pkt_mode_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    pkt_mode_next  = pkt_mode_reg;
    count_next     = count_reg;
    err_next       = err_reg;
    out_valid_next = 1'b0;
    out_data_next  = out_data_reg;
    out_count_next = out_count_reg;
    out_err_next   = out_err_reg;
    if (node_valid[0]) begin
      if (node_last[0]) begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b1;
        out_data_next  = fold_data;
        out_count_next = fold_count;
        out_err_next   = fold_err;
      end else begin
        state_next    = ST_ACC;
        acc_next      = fold_data;
        pkt_mode_next = fold_mode;
        count_next    = fold_count;
        err_next      = fold_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      pkt_mode_reg  <= '0;
      count_reg     <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      pkt_mode_reg  <= pkt_mode_next;
      count_reg     <= count_next;
      err_reg       <= err_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_count_reg <= out_count_next;
      out_err_reg   <= out_err_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;
  assign out_err   = out_err_reg;

endmodule
